// File: rtl/line_addr_seq_pkg.sv
// Shared types and width helpers for the cache-line address sequencer.
package cache_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } seq_state_e;

    function automatic int unsigned clog2_u(input int unsigned v);
        int unsigned r;
        r = 32'd0;
        for (int unsigned i = 32'd0; i < 32'd32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 32'd1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned off_w(input int unsigned line_words, input int unsigned word_bytes);
        return clog2_u(line_words * word_bytes);
    endfunction

    function automatic int unsigned idx_w(input int unsigned line_words);
        return clog2_u(line_words);
    endfunction

    function automatic int unsigned byte_w(input int unsigned word_bytes);
        return clog2_u(word_bytes);
    endfunction

endpackage

// File: rtl/line_addr_seq_beat_counter.sv
// Word index within the line (modulo LINE_WORDS) plus count of accepted beats.
module line_beat_counter
    import cache_pkg::*;
#(
    parameter  int LINE_WORDS = 4,
    localparam int IDX_W      = idx_w(LINE_WORDS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             advance,
    input  logic [IDX_W-1:0] first_idx,
    output logic [IDX_W-1:0] idx,
    output logic             last_beat
);

    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] cnt_r;

    // index and beat count; the natural IDX_W-bit rollover keeps the index inside the line
    always_ff @(posedge clk) begin
        if (clr) begin
            idx_r <= {IDX_W{1'b0}};
            cnt_r <= {IDX_W{1'b0}};
        end else if (load) begin
            idx_r <= first_idx;
            cnt_r <= {IDX_W{1'b0}};
        end else if (advance) begin
            idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            cnt_r <= cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            idx_r <= idx_r;
            cnt_r <= cnt_r;
        end
    end

    assign idx       = idx_r;
    assign last_beat = (cnt_r == IDX_W'(LINE_WORDS - 1));

endmodule

// File: rtl/line_addr_seq.sv
// Cache-line address sequencer: emits one word address per accepted beat, linear or
// critical-word-first, with a single-word bypass path while idle.
module line_addr_seq
    import cache_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int WORD_BYTES = 4,
    parameter  int LINE_WORDS = 4,
    parameter  int WRAP_EN    = 1,
    localparam int OFF_W      = off_w(LINE_WORDS, WORD_BYTES),
    localparam int IDX_W      = idx_w(LINE_WORDS),
    localparam int BYTE_W     = byte_w(WORD_BYTES)
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              start,
    input  logic              mode,
    input  logic              wrap,
    input  logic              bypass,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] addr_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [IDX_W-1:0]  word_idx,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    seq_state_e        state_r, state_nx;
    logic [ADDR_W-1:0] base_r, base_nx;
    logic [ADDR_W-1:0] addr_r, addr_nx;
    logic              req_r, req_nx;
    logic              we_r, we_nx;
    logic              done_r, done_nx;
    logic              load_s;
    logic              adv_s;
    logic              last_s;
    logic [IDX_W-1:0]  idx_s;
    logic [IDX_W-1:0]  first_s;
    logic [IDX_W-1:0]  idx_inc_s;
    logic [ADDR_W-1:0] aligned_s;

    line_beat_counter #(
        .LINE_WORDS (LINE_WORDS)
    ) u_beats (
        .clk       (CLK),
        .clr       (CLR),
        .load      (load_s),
        .advance   (adv_s),
        .first_idx (first_s),
        .idx       (idx_s),
        .last_beat (last_s)
    );

    // first-beat index and aligned base taken straight from the request address
    always_comb begin
        aligned_s = addr_in & ~OFF_MASK;
        idx_inc_s = idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
        if (wrap && (WRAP_EN != 0)) begin
            first_s = IDX_W'(addr_in >> BYTE_W);
        end else begin
            first_s = {IDX_W{1'b0}};
        end
    end

    // next-state and next-output decode
    always_comb begin
        state_nx = state_r;
        base_nx  = base_r;
        addr_nx  = addr_r;
        req_nx   = req_r;
        we_nx    = we_r;
        done_nx  = 1'b0;
        load_s   = 1'b0;
        adv_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nx = BURST;
                    base_nx  = aligned_s;
                    addr_nx  = aligned_s | (ADDR_W'(first_s) << BYTE_W);
                    req_nx   = 1'b1;
                    we_nx    = mode;
                    load_s   = 1'b1;
                end else if (bypass) begin
                    addr_nx = addr_in;
                end else begin
                    addr_nx = addr_r;
                end
            end
            BURST: begin
                if (mem_ack && last_s) begin
                    // addr_out and word_idx deliberately keep the final beat
                    state_nx = IDLE;
                    req_nx   = 1'b0;
                    we_nx    = 1'b0;
                    done_nx  = 1'b1;
                end else if (mem_ack) begin
                    adv_s   = 1'b1;
                    addr_nx = base_r | (ADDR_W'(idx_inc_s) << BYTE_W);
                end else begin
                    addr_nx = addr_r;
                end
            end
            default: begin
                state_nx = IDLE;
                req_nx   = 1'b0;
                we_nx    = 1'b0;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_r <= IDLE;
            base_r  <= {ADDR_W{1'b0}};
            addr_r  <= {ADDR_W{1'b0}};
            req_r   <= 1'b0;
            we_r    <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            base_r  <= base_nx;
            addr_r  <= addr_nx;
            req_r   <= req_nx;
            we_r    <= we_nx;
            done_r  <= done_nx;
        end
    end

    assign addr_out = addr_r;
    assign mem_req  = req_r;
    assign busy     = req_r;
    assign mem_we   = we_r;
    assign done     = done_r;
    assign word_idx = idx_s;

endmodule

// File: tb/tb_line_addr_seq.sv
// Self-checking bench: three sequencer configurations checked against an arithmetic line model.
module tb_line_addr_seq;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic [2:0]  start_v = 3'b000;
    logic        mode = 1'b0, wrap = 1'b0, bypass = 1'b0, mem_ack = 1'b0;
    logic [31:0] addr_in = 32'h0;

    logic [31:0] ao0, ao1, ao2;
    logic [1:0]  wi0, wi1;
    logic [2:0]  wi2;
    logic [2:0]  rq, we, bz, dn;
    logic [31:0] ao [3];
    logic [2:0]  ix [3];

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    line_addr_seq #(.ADDR_W(32), .WORD_BYTES(4), .LINE_WORDS(4), .WRAP_EN(1)) d0 (
        .CLK(CLK), .CLR(CLR), .start(start_v[0]), .mode(mode), .wrap(wrap), .bypass(bypass),
        .addr_in(addr_in), .mem_ack(mem_ack), .addr_out(ao0), .mem_req(rq[0]), .mem_we(we[0]),
        .word_idx(wi0), .busy(bz[0]), .done(dn[0]));

    line_addr_seq #(.ADDR_W(32), .WORD_BYTES(4), .LINE_WORDS(4), .WRAP_EN(0)) d1 (
        .CLK(CLK), .CLR(CLR), .start(start_v[1]), .mode(mode), .wrap(wrap), .bypass(bypass),
        .addr_in(addr_in), .mem_ack(mem_ack), .addr_out(ao1), .mem_req(rq[1]), .mem_we(we[1]),
        .word_idx(wi1), .busy(bz[1]), .done(dn[1]));

    line_addr_seq #(.ADDR_W(32), .WORD_BYTES(4), .LINE_WORDS(8), .WRAP_EN(1)) d2 (
        .CLK(CLK), .CLR(CLR), .start(start_v[2]), .mode(mode), .wrap(wrap), .bypass(bypass),
        .addr_in(addr_in), .mem_ack(mem_ack), .addr_out(ao2), .mem_req(rq[2]), .mem_we(we[2]),
        .word_idx(wi2), .busy(bz[2]), .done(dn[2]));

    assign ao[0] = ao0;
    assign ao[1] = ao1;
    assign ao[2] = ao2;
    assign ix[0] = {1'b0, wi0};
    assign ix[1] = {1'b0, wi1};
    assign ix[2] = wi2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full burst on DUT d; called at a negedge, returns at the negedge where done should be high.
    task automatic burst(input int d, input logic [31:0] a, input logic m, input logic w,
                         input int stall_beat, input int stall_cyc, input bit inject, input bit with_bypass);
        int unsigned lw, lb, first, wi;
        logic [31:0] base, exp_a;
        lw    = (d == 2) ? 32'd8 : 32'd4;
        lb    = lw * 32'd4;
        base  = a & ~(lb - 32'd1);
        first = (w && d != 1) ? (a % lb) / 32'd4 : 32'd0;
        start_v[d] = 1'b1;
        bypass  = with_bypass;
        addr_in = a;
        mode    = m;
        wrap    = w;
        mem_ack = 1'b0;
        @(negedge CLK);
        start_v[d] = 1'b0;
        bypass = 1'b0;
        exp_a = base;
        for (int k = 0; k < int'(lw); k++) begin
            wi    = (first + k) % lw;
            exp_a = base + wi * 32'd4;
            if (k == stall_beat) begin
                for (int s = 0; s < stall_cyc; s++) begin
                    mem_ack = 1'b0;
                    chk("stall_addr", ao[d], exp_a);
                    chk("stall_req", {31'd0, rq[d]}, 32'd1);
                    @(negedge CLK);
                end
            end
            mem_ack = 1'b1;
            chk("beat_addr", ao[d], exp_a);
            chk("beat_idx", {29'd0, ix[d]}, wi);
            chk("beat_req", {31'd0, rq[d]}, 32'd1);
            chk("beat_busy", {31'd0, bz[d]}, 32'd1);
            chk("beat_we", {31'd0, we[d]}, {31'd0, m});
            chk("beat_done", {31'd0, dn[d]}, 32'd0);
            if (inject) begin
                start_v[d] = 1'b1;
                bypass  = 1'b1;
                addr_in = $urandom;
                mode    = ~m;
                wrap    = ~w;
            end
            @(negedge CLK);
            start_v[d] = 1'b0;
            bypass = 1'b0;
        end
        mem_ack = 1'b0;
        chk("end_done", {31'd0, dn[d]}, 32'd1);
        chk("end_req", {31'd0, rq[d]}, 32'd0);
        chk("end_busy", {31'd0, bz[d]}, 32'd0);
        chk("end_we", {31'd0, we[d]}, 32'd0);
        chk("end_addr", ao[d], exp_a);
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge CLK);
        CLR = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("rst_addr", ao[d], 32'h0);
            chk("rst_req", {31'd0, rq[d]}, 32'd0);
            chk("rst_busy", {31'd0, bz[d]}, 32'd0);
            chk("rst_done", {31'd0, dn[d]}, 32'd0);
            chk("rst_idx", {29'd0, ix[d]}, 32'd0);
        end

        // linear fill, then done low on the following cycle
        burst(0, 32'h0000_1234, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("done_once", {31'd0, dn[0]}, 32'd0);
        chk("idle_hold", ao[0], 32'h0000_123C);

        // wrap order, same stimulus with wrap disabled, and a stall on beat 2
        burst(0, 32'h0000_1238, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0);
        burst(1, 32'h0000_1238, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0);
        burst(0, 32'h0000_1234, 1'b0, 1'b0, 1, 3, 1'b0, 1'b0);
        @(negedge CLK);

        // bypass while idle
        bypass  = 1'b1;
        addr_in = 32'hDEAD_BEEF;
        @(negedge CLK);
        bypass = 1'b0;
        chk("byp_addr", ao[0], 32'hDEAD_BEEF);
        chk("byp_req", {31'd0, rq[0]}, 32'd0);
        chk("byp_busy", {31'd0, bz[0]}, 32'd0);
        chk("byp_done", {31'd0, dn[0]}, 32'd0);

        // start+bypass together, requests injected mid-burst, then done+start back-to-back
        burst(0, 32'h0000_5678, 1'b0, 1'b1, -1, 0, 1'b1, 1'b1);
        burst(0, 32'h0000_9AB4, 1'b1, 1'b1, 2, 2, 1'b0, 1'b0);

        // reset after the second ack
        start_v[0] = 1'b1;
        addr_in = 32'h0000_1234;
        wrap = 1'b0;
        @(negedge CLK);
        start_v[0] = 1'b0;
        mem_ack = 1'b1;
        repeat (2) @(negedge CLK);
        mem_ack = 1'b0;
        CLR = 1'b1;
        @(negedge CLK);
        CLR = 1'b0;
        chk("clr_addr", ao[0], 32'h0);
        chk("clr_req", {31'd0, rq[0]}, 32'd0);
        chk("clr_busy", {31'd0, bz[0]}, 32'd0);
        chk("clr_done", {31'd0, dn[0]}, 32'd0);
        @(negedge CLK);
        chk("clr_nodone", {31'd0, dn[0]}, 32'd0);
        burst(0, 32'h0000_0040, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0);
        @(negedge CLK);

        // write-back at the top of the address space, 8-word line
        burst(2, 32'hFFFF_FFE4, 1'b1, 1'b0, -1, 0, 1'b0, 1'b0);
        burst(2, 32'hFFFF_FFF4, 1'b0, 1'b1, 4, 1, 1'b0, 1'b0);
        @(negedge CLK);

        // randomized bursts across all configurations
        for (int n = 0; n < 24; n++) begin
            burst(int'($urandom_range(2, 0)), $urandom, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                  int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
                  1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            if ($urandom_range(1, 0) == 1) @(negedge CLK);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
